vec_alu_mc: RTL
===============

VEC_ALU_MC -- requirements
Module: vec_alu_mc

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning the number of vector lanes.
REQ-002 The block SHALL have parameter LANE_W, default 16, meaning the lane width in bits.
REQ-003 The block SHALL have parameter LPC, default 4, meaning lanes processed per cycle; LANES SHALL be a multiple of LPC, checked at elaboration.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operation request valid.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 opcode  in  4  operation select.
REQ-009 op_1  in  LANES*LANE_W  vector operand A; lane i occupies bits [i*LANE_W +: LANE_W].
REQ-010 op_2  in  LANES*LANE_W  vector operand B; lane 0 is the scalar for SMUL.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 result  out  LANES*LANE_W  result vector.
REQ-014 illegal  out  1  the held result came from an unsupported opcode.

Function
REQ-015 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; opcode, op_1 and op_2 SHALL be captured on that edge and later input changes SHALL be ignored.
REQ-016 The FSM SHALL have states IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 IDLE SHALL go to EXEC on acceptance; EXEC SHALL last exactly N = LANES/LPC cycles, with a beat counter running 0..N-1; EXEC SHALL go to DONE after beat N-1.
REQ-018 Each EXEC beat b SHALL process lanes b*LPC .. b*LPC+LPC-1.
REQ-019 Latency: if acceptance is at edge k, out_valid SHALL rise at edge k+N (default k+4).
REQ-020 VADD (4'h0): result lane i SHALL be (A[i]+B[i]) mod 2^LANE_W.
REQ-021 VDOT (4'h1): lane 0 SHALL be sum over i of A[i]*B[i], mod 2^LANE_W, accumulated across beats in a LANE_W-bit accumulator cleared on acceptance; lanes 1..LANES-1 SHALL be 0.
REQ-022 SMUL (4'h2): result lane i SHALL be (A[i]*B[0]) mod 2^LANE_W.
REQ-023 VLD (4'h4) and VST (4'h5): lane 0 SHALL be (A[0]+B[0]) mod 2^LANE_W (address generation); other lanes SHALL be 0.
REQ-024 Any other opcode SHALL still take N EXEC cycles, produce result all zero, and set illegal=1; illegal SHALL be 0 for supported opcodes.
REQ-025 All arithmetic SHALL be unsigned and wrap, with no saturation and no overflow flag.
REQ-026 In DONE, result and illegal SHALL hold stable until out_ready=1; the handshake edge SHALL return the FSM to IDLE, and in_ready SHALL be 1 on the following cycle.
REQ-027 out_ready while not in DONE, and in_valid while not in IDLE, SHALL have no effect.
REQ-028 Result lanes not yet written in the current operation SHALL read 0; the result register SHALL be cleared on acceptance.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force: FSM to IDLE, beat counter 0, accumulator 0, result 0, illegal 0, out_valid 0, and in_ready 1 once rst_n=1.
REQ-030 Reset during EXEC or DONE SHALL discard the in-flight operation, and no out_valid SHALL follow it.

Structure
REQ-031 Package vec_alu_pkg SHALL hold the opcode constants (VADD, VDOT, SMUL, VLD, VST) and the FSM state type.
REQ-032 One sub-module, vec_lane_unit, SHALL compute the per-lane sum and product for a single LANE_W lane; it SHALL be instantiated LPC times, and the VDOT adder tree SHALL live in the top level.

Verification
REQ-033 Reset, then VADD with A lanes = i and B lanes = 0x0100 -> out_valid at acceptance+4 with lane i = 0x0100+i, illegal = 0.
REQ-034 VADD with A lanes = 0xFFFF and B lanes = 0x0002 -> every lane = 0x0001 (wrap).
REQ-035 VDOT with A lanes = 2 and B lanes = 3 (16 lanes) -> lane 0 = 96, lanes 1..15 = 0; then SMUL with A lanes = i and B[0] = 5 -> lane i = 5*i.
REQ-036 Hold out_ready = 0 for 10 cycles in DONE while changing op_1 and in_valid -> result stable, in_ready = 0, exactly one transfer when out_ready = 1.
REQ-037 opcode 4'hF -> result all zero and illegal = 1 after 4 EXEC cycles; assert rst_n = 0 during the second EXEC beat of a VADD -> out_valid stays 0 and in_ready = 1 after release.
REQ-038 Rerun REQ-033 with LANES = 8, LANE_W = 32, LPC = 8 -> out_valid at acceptance+1.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared definitions for the multi-cycle vector ALU.
//   - opcode constants (VADD, VDOT, SMUL, VLD, VST)
//   - FSM state type
//   - op_supported(): true for opcodes the datapath implements
package vec_alu_pkg;

  localparam logic [3:0] VADD = 4'h0;
  localparam logic [3:0] VDOT = 4'h1;
  localparam logic [3:0] SMUL = 4'h2;
  localparam logic [3:0] VLD  = 4'h4;
  localparam logic [3:0] VST  = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  function automatic logic op_supported(input logic [3:0] op);
    logic ok;
    case (op)
      VADD, VDOT, SMUL, VLD, VST: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vec_alu_mc_if.sv
// Request/response bus of the vector ALU.
//   in_valid/in_ready  : request handshake, carries opcode, op_1, op_2
//   out_valid/out_ready: response handshake, carries result, illegal
// master = requester/consumer side, slave = ALU side.
interface vec_alu_mc_if #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                opcode;
  logic [LANES*LANE_W-1:0]   op_1;
  logic [LANES*LANE_W-1:0]   op_2;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   result;
  logic                      illegal;

  modport master (
    output in_valid, opcode, op_1, op_2, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, opcode, op_1, op_2, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/vec_lane_unit.sv
// Single-lane arithmetic: wrapping sum and product of two LANE_W operands.
//   i_a, i_b : lane operands
//   o_sum    : (i_a + i_b) mod 2^LANE_W
//   o_prod   : (i_a * i_b) mod 2^LANE_W
module vec_lane_unit #(
  parameter int unsigned LANE_W = 16
) (
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_sum,
  output logic [LANE_W-1:0] o_prod
);
  assign o_sum  = i_a + i_b;
  assign o_prod = i_a * i_b;
endmodule

// File: rtl/vec_alu_mc.sv
// Multi-cycle vector ALU. A request is captured on acceptance, then processed
// LPC lanes per cycle over N = LANES/LPC EXEC beats; the result is held in
// DONE until the consumer takes it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response bus (slave side), see vec_alu_mc_if
module vec_alu_mc
  import vec_alu_pkg::*;
#(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned LPC    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  vec_alu_mc_if.slave  bus
);

  localparam int unsigned N   = LANES / LPC;
  localparam int unsigned BW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LIW = (LANES > 1) ? $clog2(LANES) : 1;

  if ((LANES % LPC) != 0) begin : g_lpc_check
    $error("vec_alu_mc: LANES must be a multiple of LPC");
  end

  state_t              r_state, w_next;
  logic [BW-1:0]       r_beat;
  logic [3:0]          r_opcode;
  logic                r_illegal;
  logic [LANE_W-1:0]   r_acc;
  logic [LANE_W-1:0]   r_a   [LANES];
  logic [LANE_W-1:0]   r_b   [LANES];
  logic [LANE_W-1:0]   r_res [LANES];

  logic                w_accept;
  logic                w_last;
  logic [LIW-1:0]      w_idx  [LPC];
  logic [LANE_W-1:0]   w_la   [LPC];
  logic [LANE_W-1:0]   w_lb   [LPC];
  logic [LANE_W-1:0]   w_sum  [LPC];
  logic [LANE_W-1:0]   w_prod [LPC];
  logic [LANE_W-1:0]   w_dot;
  logic [LANE_W-1:0]   w_acc_next;

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
  assign w_last   = (r_beat == BW'(N - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Lane selection for the current beat; SMUL broadcasts B lane 0.
  // When N == 1 the beat is always 0, so a truncated LPC in the product is harmless.
  always_comb begin
    for (int unsigned j = 0; j < LPC; j++) begin
      w_idx[j] = LIW'(r_beat) * LIW'(LPC) + LIW'(j);
      w_la[j]  = r_a[w_idx[j]];
      w_lb[j]  = (r_opcode == SMUL) ? r_b[0] : r_b[w_idx[j]];
    end
  end

  for (genvar g = 0; g < LPC; g++) begin : g_lane
    vec_lane_unit #(.LANE_W(LANE_W)) u_lane (
      .i_a    (w_la[g]),
      .i_b    (w_lb[g]),
      .o_sum  (w_sum[g]),
      .o_prod (w_prod[g])
    );
  end

  // VDOT reduction of this beat's products
  always_comb begin
    w_dot = '0;
    for (int unsigned j = 0; j < LPC; j++) begin
      w_dot = w_dot + w_prod[j];
    end
    w_acc_next = r_acc + w_dot;
  end

  // Operand capture and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= '0;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
      r_acc     <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_res[i] <= '0;
      end
    end else if (w_accept) begin
      r_beat    <= '0;
      r_opcode  <= bus.opcode;
      r_illegal <= !op_supported(bus.opcode);
      r_acc     <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        r_a[i]   <= bus.op_1[i*LANE_W +: LANE_W];
        r_b[i]   <= bus.op_2[i*LANE_W +: LANE_W];
        r_res[i] <= '0;
      end
    end else if (r_state == ST_EXEC) begin
      r_beat <= w_last ? '0 : r_beat + 1'b1;
      case (r_opcode)
        VADD: for (int unsigned j = 0; j < LPC; j++) r_res[w_idx[j]] <= w_sum[j];
        SMUL: for (int unsigned j = 0; j < LPC; j++) r_res[w_idx[j]] <= w_prod[j];
        VDOT: begin
          r_acc    <= w_acc_next;
          r_res[0] <= w_acc_next;
        end
        // address generation uses lane 0 only, which is processed on beat 0
        VLD, VST: if (r_beat == '0) r_res[0] <= w_sum[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.result  = '0;
    bus.illegal = r_illegal;
    for (int unsigned i = 0; i < LANES; i++) begin
      bus.result[i*LANE_W +: LANE_W] = r_res[i];
    end
  end

endmodule
